coin_acceptor: RTL and testbench

//  Front-end payment stage directly upstream of the washing machine controller.

---
 rtl/washer_pkg.sv | 35 +++
 rtl/coin_debounce.sv | 80 ++++++++
 rtl/coin_acceptor.sv | 180 ++++++++++++++++++
 tb/tb_coin_acceptor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// -----------------------------------------------------------------------------
// washer_pkg
// Shared types and helpers for the coin acceptor front-end.
//   state_e      : payment FSM states
//   COIN_*       : 2-bit denomination codes as presented on coin_value
//   coin_units() : maps a denomination code to credit units (0 for invalid)
// -----------------------------------------------------------------------------
package washer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VEND    = 3'd2,
    ST_RUN     = 3'd3,
    ST_REFUND  = 3'd4
  } state_e;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_2   = 2'b01;
  localparam logic [1:0] COIN_5   = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  // Credit units for a denomination code; the invalid code is worth nothing.
  function automatic logic [2:0] coin_units(input logic [1:0] code);
    logic [2:0] units;
    case (code)
      COIN_1:  units = 3'd1;
      COIN_2:  units = 3'd2;
      COIN_5:  units = 3'd5;
      default: units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// -----------------------------------------------------------------------------
// coin_debounce
// Synchronises the raw coin-sensor level and turns each sufficiently long high
// period into a single one-cycle event, capturing the denomination with it.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw_i      : coin sensor level, asynchronous to clk
//   value_i    : denomination code, captured when the event fires
//   event_o    : one-cycle pulse per accepted high period
//   value_o    : denomination captured with the most recent event
// After an event the input must read low for DEBOUNCE_CYC consecutive synced
// samples before the debouncer re-arms, so short dropouts inside one long
// pulse cannot produce a second coin.
// -----------------------------------------------------------------------------
module coin_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_i,
  input  logic [1:0] value_i,
  output logic       event_o,
  output logic [1:0] value_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          armed_q;
  logic          event_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      armed_q <= 1'b1;
      event_q <= 1'b0;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      event_q <= 1'b0;
      if (armed_q) begin
        // Count consecutive high samples; fire once on the last one.
        if (sync2_q) begin
          if (cnt_q == LAST) begin
            event_q <= 1'b1;
            value_q <= value_i;
            armed_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end else begin
        // Re-arm only after a stable low period of the same length.
        if (!sync2_q) begin
          if (cnt_q == LAST) begin
            armed_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

  assign event_o = event_q;
  assign value_o = value_q;

endmodule

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
// Payment front-end for the washing machine controller: debounces coins,
// accumulates credit, vends a single or double wash, returns change and
// blocks further coins until the controller reports wash_done.
//   clk, rst_n   : clock, asynchronous active-low reset
//   coin_valid   : raw coin sensor level (asynchronous)
//   coin_value   : 00=1, 01=2, 10=5, 11=invalid
//   double_req   : double-wash selection, sampled at the vend decision
//   cancel       : refund request (level)
//   wash_done    : cycle-done pulse from the controller
//   coin_in      : one-cycle start pulse to the controller
//   double_wash  : double-wash flag, held through RUN
//   credit       : accumulated credit
//   change_valid : one-cycle pulse qualifying change_value
//   change_value : units to dispense
//   reject       : one-cycle pulse, coin returned with credit unchanged
//   busy         : high in VEND and RUN
// Build option: define COIN_ACCEPTOR_TIMEOUT_EN to refund automatically after
// TIMEOUT_CYC cycles in COLLECT without an accepted coin.
// -----------------------------------------------------------------------------
module coin_acceptor
  import washer_pkg::*;
#(
  parameter int PRICE_SINGLE = 4,
  parameter int PRICE_DOUBLE = 6,
  parameter int CREDIT_W     = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                double_req,
  input  logic                cancel,
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_value,
  output logic                reject,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] PRICE_S = CREDIT_W'(PRICE_SINGLE);
  localparam logic [CREDIT_W-1:0] PRICE_D = CREDIT_W'(PRICE_DOUBLE);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_value_q;
  logic                coin_in_q;
  logic                double_wash_q;
  logic                change_valid_q;
  logic                reject_q;
  logic                busy_q;

  logic                ev;
  logic [1:0]          ev_value;
  logic [SUM_W-1:0]    sum_w;
  logic [CREDIT_W-1:0] price_w;
  logic                coin_ok;
  logic                coin_accept;
  logic                timeout_hit;

  coin_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (coin_valid),
    .value_i(coin_value),
    .event_o(ev),
    .value_o(ev_value)
  );

  // One extra bit so an overflowing coin is detected instead of wrapping.
  assign sum_w   = {1'b0, credit_q} + SUM_W'(coin_units(ev_value));
  assign price_w = double_req ? PRICE_D : PRICE_S;

  always_comb begin
    coin_ok     = ev && (ev_value != COIN_BAD) && !sum_w[CREDIT_W] && !cancel;
    coin_accept = 1'b0;
    case (state_q)
      ST_IDLE:    coin_accept = coin_ok;
      // A coin arriving on the vend or refund decision cycle is returned.
      ST_COLLECT: coin_accept = coin_ok && !timeout_hit && (credit_q < price_w);
      default:    coin_accept = 1'b0;
    endcase
  end

`ifdef COIN_ACCEPTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else if ((state_q != ST_COLLECT) || coin_accept) begin
      idle_cnt_q <= '0;
    end else if (!timeout_hit) begin
      idle_cnt_q <= idle_cnt_q + TW'(1);
    end
  end

  assign timeout_hit = (state_q == ST_COLLECT) && (idle_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  // Timeout disabled: credit is held in COLLECT indefinitely.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      change_value_q <= '0;
      coin_in_q      <= 1'b0;
      double_wash_q  <= 1'b0;
      change_valid_q <= 1'b0;
      reject_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      coin_in_q      <= 1'b0;
      change_valid_q <= 1'b0;
      reject_q       <= ev && !coin_accept;
      case (state_q)
        ST_IDLE: begin
          if (coin_accept) begin
            credit_q <= sum_w[CREDIT_W-1:0];
            state_q  <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (cancel || timeout_hit) begin
            change_value_q <= credit_q;
            change_valid_q <= 1'b1;
            state_q        <= ST_REFUND;
          end else if (credit_q >= price_w) begin
            // Vend outputs are registered here so they appear during VEND.
            coin_in_q      <= 1'b1;
            double_wash_q  <= double_req;
            busy_q         <= 1'b1;
            change_value_q <= credit_q - price_w;
            change_valid_q <= (credit_q != price_w);
            state_q        <= ST_VEND;
          end else if (coin_accept) begin
            credit_q <= sum_w[CREDIT_W-1:0];
          end
        end
        ST_VEND: begin
          credit_q <= '0;
          state_q  <= ST_RUN;
        end
        ST_RUN: begin
          if (wash_done) begin
            double_wash_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        ST_REFUND: begin
          credit_q <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign coin_in      = coin_in_q;
  assign double_wash  = double_wash_q;
  assign credit       = credit_q;
  assign change_valid = change_valid_q;
  assign change_value = change_value_q;
  assign reject       = reject_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
// Directed bench for coin_acceptor. A main instance (prices 4/6, 4-bit credit)
// is checked through an event scoreboard of expected vend/refund/reject pulses
// plus direct credit/busy/double_wash checks; a second instance with 3-bit
// credit and price 7 exercises credit overflow rejection.
// Expectations for the auto-refund step follow COIN_ACCEPTOR_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

  localparam int DEB  = 4;
  localparam int TOUT = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // main instance
  logic       cv_m, dreq_m, cancel_m, done_m;
  logic [1:0] val_m;
  logic       coin_in_m, dw_m, chv_m, rej_m, busy_m;
  logic [3:0] credit_m, chval_m;

  // small instance
  logic       cv_s, dreq_s, cancel_s, done_s;
  logic [1:0] val_s;
  logic       coin_in_s, dw_s, chv_s, rej_s, busy_s;
  logic [2:0] credit_s, chval_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       coin_in;
    logic       chv;
    logic       rej;
    logic [3:0] chval;
    logic       dw;
    logic [3:0] credit;
  } obs_t;

  obs_t exp_q[$];

  coin_acceptor #(
    .PRICE_SINGLE(4), .PRICE_DOUBLE(6), .CREDIT_W(4),
    .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TOUT)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .coin_valid(cv_m), .coin_value(val_m),
    .double_req(dreq_m), .cancel(cancel_m), .wash_done(done_m),
    .coin_in(coin_in_m), .double_wash(dw_m), .credit(credit_m),
    .change_valid(chv_m), .change_value(chval_m), .reject(rej_m), .busy(busy_m)
  );

  coin_acceptor #(
    .PRICE_SINGLE(7), .PRICE_DOUBLE(7), .CREDIT_W(3),
    .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TOUT)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .coin_valid(cv_s), .coin_value(val_s),
    .double_req(dreq_s), .cancel(cancel_s), .wash_done(done_s),
    .coin_in(coin_in_s), .double_wash(dw_s), .credit(credit_s),
    .change_valid(chv_s), .change_value(chval_s), .reject(rej_s), .busy(busy_s)
  );

  function automatic obs_t mk(input logic ci, input logic chv, input logic rej,
                              input logic [3:0] chval, input logic dw,
                              input logic [3:0] cr);
    obs_t o;
    o = {ci, chv, rej, chval, dw, cr};
    return o;
  endfunction

  // Scoreboard: every output pulse of the main instance must match the
  // oldest expected event.
  always @(negedge clk) begin : monitor
    obs_t o;
    obs_t e;
    if (rst_n && (coin_in_m || chv_m || rej_m)) begin
      o = {coin_in_m, chv_m, rej_m, (chv_m ? chval_m : 4'd0), (coin_in_m & dw_m), credit_m};
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed %h required no event", o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("[TB] event observed %h expected %h", o, e);
        assert (o === e) else begin
          n_fail++;
          $error("FAIL sb_event: observed %h required %h", o, e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    $display("[TB] %s observed %0d expected %0d", tag, obs, expv);
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one coin for 'hold' cycles, then leave the line low long enough
  // for the debouncer to re-arm and the FSM to settle.
  task automatic coin_m(input logic [1:0] v, input int hold);
    val_m = v;
    cv_m  = 1'b1;
    cycles(hold);
    cv_m  = 1'b0;
    cycles(3 * DEB + 4);
  endtask

  task automatic coin_s(input logic [1:0] v, input int hold);
    val_s = v;
    cv_s  = 1'b1;
    cycles(hold);
    cv_s  = 1'b0;
    cycles(3 * DEB + 4);
  endtask

  task automatic pulse_done_m();
    done_m = 1'b1;
    cycles(1);
    done_m = 1'b0;
    cycles(2);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit got;
    rst_n = 1'b0;
    cv_m = 0; val_m = 0; dreq_m = 0; cancel_m = 0; done_m = 0;
    cv_s = 0; val_s = 0; dreq_s = 0; cancel_s = 0; done_s = 0;
    cycles(3);

    // Reset state
    check("rst_credit", credit_m, 0);
    check("rst_coin_in", coin_in_m, 0);
    check("rst_double_wash", dw_m, 0);
    check("rst_change_valid", chv_m, 0);
    check("rst_change_value", chval_m, 0);
    check("rst_reject", rej_m, 0);
    check("rst_busy", busy_m, 0);
    rst_n = 1'b1;
    cycles(2);

    // 1: coins 2,2 single wash, exact price
    dreq_m = 1'b0;
    coin_m(2'b01, 6);
    check("t1_credit2", credit_m, 2);
    check("t1_idle_busy", busy_m, 0);
    exp_q.push_back(mk(1, 0, 0, 4'd0, 0, 4'd4));
    coin_m(2'b01, 6);
    check("t1_busy", busy_m, 1);
    check("t1_credit_cleared", credit_m, 0);
    cycles(20);
    check("t1_busy_hold", busy_m, 1);
    pulse_done_m();
    check("t1_done_busy", busy_m, 0);

    // 2: coins 5,2 double wash, change 1
    dreq_m = 1'b1;
    coin_m(2'b10, 6);
    check("t2_credit5", credit_m, 5);
    exp_q.push_back(mk(1, 1, 0, 4'd1, 1, 4'd7));
    coin_m(2'b01, 6);
    check("t2_double_wash", dw_m, 1);
    check("t2_busy", busy_m, 1);
    dreq_m = 1'b0;
    cycles(10);
    check("t2_dw_hold", dw_m, 1);
    // coin during RUN is returned
    exp_q.push_back(mk(0, 0, 1, 4'd0, 0, 4'd0));
    coin_m(2'b01, 6);
    check("t2_run_credit", credit_m, 0);
    pulse_done_m();
    check("t2_dw_cleared", dw_m, 0);
    check("t2_idle_busy", busy_m, 0);

    // 3: short pulse ignored, glitchy long pulse counted once
    coin_m(2'b00, DEB - 1);
    check("t3_short_pulse", credit_m, 0);
    val_m = 2'b00;
    cv_m = 1'b1; cycles(6);
    cv_m = 1'b0; cycles(1);
    cv_m = 1'b1; cycles(6);
    cv_m = 1'b0; cycles(1);
    cv_m = 1'b1; cycles(6);
    cv_m = 1'b0; cycles(3 * DEB + 4);
    check("t3_glitch_once", credit_m, 1);

    // 4: credit 3, cancel -> refund 3
    coin_m(2'b01, 6);
    check("t4_credit3", credit_m, 3);
    exp_q.push_back(mk(0, 1, 0, 4'd3, 0, 4'd3));
    cancel_m = 1'b1;
    cycles(1);
    cancel_m = 1'b0;
    cycles(3);
    check("t4_refund_credit", credit_m, 0);
    check("t4_refund_busy", busy_m, 0);
    // coin with cancel held: prior credit refunded, coin rejected
    coin_m(2'b00, 6);
    check("t4_credit1", credit_m, 1);
    exp_q.push_back(mk(0, 1, 0, 4'd1, 0, 4'd1));
    exp_q.push_back(mk(0, 0, 1, 4'd0, 0, 4'd0));
    cancel_m = 1'b1;
    coin_m(2'b01, 6);
    cancel_m = 1'b0;
    check("t4_cancel_coin_credit", credit_m, 0);

    // 5: invalid code rejected; overflow rejected on the 3-bit instance
    exp_q.push_back(mk(0, 0, 1, 4'd0, 0, 4'd0));
    coin_m(2'b11, 6);
    check("t5_invalid_credit", credit_m, 0);
    coin_s(2'b10, 6);
    check("t5_small_credit5", credit_s, 5);
    val_s = 2'b10;
    cv_s  = 1'b1;
    got   = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rej_s) got = 1'b1;
    end
    cv_s = 1'b0;
    check("t5_overflow_reject", got, 1);
    cycles(3 * DEB + 4);
    check("t5_overflow_credit", credit_s, 5);

    // 6: idle credit with and without auto-refund
    coin_m(2'b01, 6);
    check("t6_credit2", credit_m, 2);
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
    exp_q.push_back(mk(0, 1, 0, 4'd2, 0, 4'd2));
    cycles(TOUT + 20);
    check("t6_timeout_credit", credit_m, 0);
`else
    cycles(TOUT + 20);
    check("t6_hold_credit", credit_m, 2);
    exp_q.push_back(mk(0, 1, 0, 4'd2, 0, 4'd2));
    cancel_m = 1'b1;
    cycles(1);
    cancel_m = 1'b0;
    cycles(3);
    check("t6_cancel_credit", credit_m, 0);
`endif

    // reset during RUN
    dreq_m = 1'b1;
    coin_m(2'b10, 6);
    exp_q.push_back(mk(1, 1, 0, 4'd1, 1, 4'd7));
    coin_m(2'b01, 6);
    check("t6_run_busy", busy_m, 1);
    check("t6_run_dw", dw_m, 1);
    rst_n = 1'b0;
    #2;
    check("t6_rst_busy", busy_m, 0);
    check("t6_rst_dw", dw_m, 0);
    check("t6_rst_credit", credit_m, 0);
    check("t6_rst_change_value", chval_m, 0);
    check("t6_rst_coin_in", coin_in_m, 0);
    cycles(2);
    rst_n = 1'b1;
    dreq_m = 1'b0;
    cycles(4);
    check("t6_post_busy", busy_m, 0);
    check("t6_post_credit", credit_m, 0);

    // small instance idle after reset
    check("small_credit", credit_s, 0);
    check("small_coin_in", coin_in_s, 0);
    check("small_dw", dw_s, 0);
    check("small_chv", chv_s, 0);
    check("small_chval", chval_s, 0);
    check("small_busy", busy_s, 0);

    check("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
